// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the UART command line parser
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARG     = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_OP   = 2'd1;
    localparam logic [1:0] ERR_BAD_CHAR = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] SP = 8'h20;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// rtl/hex_nibble_decode.sv - ASCII hex character to 4-bit nibble decoder
module hex_nibble_decode (
    input  logic [7:0] i_char,
    output logic [3:0] o_nibble,
    output logic       o_is_hex
);

    always_comb begin
        o_nibble = 4'h0;
        o_is_hex = 1'b0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_nibble = i_char[3:0];
            o_is_hex = 1'b1;
        end else if ((i_char >= 8'h61 && i_char <= 8'h66) ||
                     (i_char >= 8'h41 && i_char <= 8'h46)) begin
            // 'a'/'A' have low nibble 1, so +9 maps them to 10
            o_nibble = i_char[3:0] + 4'd9;
            o_is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles "<op>[spaces]<hex>\r" lines into decoded commands
// Optional byte echo stream enabled by defining UART_CMD_ECHO_EN.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int MAX_LINE  = 16
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    input  logic [7:0]           uart_out_data,
    input  logic                 uart_out_valid,
    output logic                 uart_out_ready,
    output logic [7:0]           cmd_op,
    output logic [DATA_BITS-1:0] cmd_arg,
    output logic                 cmd_has_arg,
    output logic [1:0]           cmd_err,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [7:0]           echo_data,
    output logic                 echo_valid,
    input  logic                 echo_ready
);

    localparam int MAX_DIGITS = DATA_BITS / 4;
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int LW = $clog2(MAX_LINE + 1);

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_op, w_op_nxt;
    logic [DATA_BITS-1:0]   r_arg, w_arg_nxt;
    logic                   r_has_arg, w_has_arg_nxt;
    logic [1:0]             r_err, w_err_nxt;
    logic [DW-1:0]          r_digits, w_digits_nxt;
    logic [LW-1:0]          r_len, w_len_nxt;
    logic                   r_ready, w_ready_nxt;
    logic                   w_accept;
    logic                   w_echo_room;
    logic                   w_fault;
    logic [1:0]             w_fault_code;
    logic [3:0]             w_nibble;
    logic                   w_is_hex;

    hex_nibble_decode u_hex (
        .i_char   (uart_out_data),
        .o_nibble (w_nibble),
        .o_is_hex (w_is_hex)
    );

`ifdef UART_CMD_ECHO_EN
    logic       r_echo_valid;
    logic [7:0] r_echo_data;

    assign w_echo_room = !r_echo_valid || echo_ready;

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_valid <= 1'b0;
            r_echo_data  <= 8'h00;
        end else if (w_accept) begin
            r_echo_valid <= 1'b1;
            r_echo_data  <= uart_out_data;
        end else if (echo_ready) begin
            r_echo_valid <= 1'b0;
        end
    end

    assign echo_valid = r_echo_valid;
    assign echo_data  = r_echo_data;
`else
    logic w_unused_echo_ready;
    assign w_unused_echo_ready = echo_ready;
    assign w_echo_room = 1'b1;
    assign echo_valid  = 1'b0;
    assign echo_data   = 8'h00;
`endif

    assign uart_out_ready = r_ready && w_echo_room;
    assign w_accept       = uart_out_valid && uart_out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_arg_nxt     = r_arg;
        w_has_arg_nxt = r_has_arg;
        w_err_nxt     = r_err;
        w_digits_nxt  = r_digits;
        w_len_nxt     = r_len;
        w_fault       = 1'b0;
        w_fault_code  = ERR_NONE;

        case (r_state)
            IDLE: begin
                if (w_accept && uart_out_data != LF && uart_out_data != CR) begin
                    if (is_lower(uart_out_data)) begin
                        w_op_nxt      = uart_out_data;
                        w_arg_nxt     = '0;
                        w_has_arg_nxt = 1'b0;
                        w_digits_nxt  = '0;
                        w_len_nxt     = LW'(1);
                        w_err_nxt     = ERR_NONE;
                        w_state_nxt   = ARG;
                    end else begin
                        w_op_nxt     = 8'h00;
                        w_fault      = 1'b1;
                        w_fault_code = ERR_BAD_OP;
                    end
                end
            end
            ARG: begin
                if (w_accept && uart_out_data != LF) begin
                    if (uart_out_data == CR) begin
                        w_state_nxt = HOLD;
                    end else if (r_len == LW'(MAX_LINE)) begin
                        // Line length is judged before the character itself
                        w_fault      = 1'b1;
                        w_fault_code = ERR_OVERFLOW;
                    end else begin
                        w_len_nxt = r_len + 1'b1;
                        if (uart_out_data == SP) begin
                            if (r_digits != '0) begin
                                w_fault      = 1'b1;
                                w_fault_code = ERR_BAD_CHAR;
                            end
                        end else if (w_is_hex) begin
                            if (r_digits == DW'(MAX_DIGITS)) begin
                                w_fault      = 1'b1;
                                w_fault_code = ERR_OVERFLOW;
                            end else begin
                                w_arg_nxt     = {r_arg[DATA_BITS-5:0], w_nibble};
                                w_digits_nxt  = r_digits + 1'b1;
                                w_has_arg_nxt = 1'b1;
                            end
                        end else begin
                            w_fault      = 1'b1;
                            w_fault_code = ERR_BAD_CHAR;
                        end
                    end
                end
            end
            DISCARD: begin
                if (w_accept && uart_out_data == CR) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_fault) begin
            w_err_nxt     = w_fault_code;
            w_arg_nxt     = '0;
            w_has_arg_nxt = 1'b0;
            w_state_nxt   = DISCARD;
        end

        w_ready_nxt = (w_state_nxt != HOLD);
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= 8'h00;
            r_arg     <= '0;
            r_has_arg <= 1'b0;
            r_err     <= ERR_NONE;
            r_digits  <= '0;
            r_len     <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_op      <= w_op_nxt;
            r_arg     <= w_arg_nxt;
            r_has_arg <= w_has_arg_nxt;
            r_err     <= w_err_nxt;
            r_digits  <= w_digits_nxt;
            r_len     <= w_len_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign cmd_op      = r_op;
    assign cmd_arg     = r_arg;
    assign cmd_has_arg = r_has_arg;
    assign cmd_err     = r_err;
    assign cmd_valid   = (r_state == HOLD);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - scoreboard bench for uart_cmd_parser with a line-level reference model
module tb_uart_cmd_parser;

    localparam int DATA_BITS = 32;
    localparam int MAX_LINE  = 16;

    logic                 clk_48mhz = 1'b0;
    logic                 reset_n = 1'b0;
    logic [7:0]           uart_out_data = 8'h00;
    logic                 uart_out_valid = 1'b0;
    logic                 uart_out_ready;
    logic [7:0]           cmd_op;
    logic [DATA_BITS-1:0] cmd_arg;
    logic                 cmd_has_arg;
    logic [1:0]           cmd_err;
    logic                 cmd_valid;
    logic                 cmd_ready = 1'b0;
    logic [7:0]           echo_data;
    logic                 echo_valid;
    logic                 echo_ready = 1'b1;

    uart_cmd_parser #(.DATA_BITS(DATA_BITS), .MAX_LINE(MAX_LINE)) dut (
        .clk_48mhz      (clk_48mhz),
        .reset_n        (reset_n),
        .uart_out_data  (uart_out_data),
        .uart_out_valid (uart_out_valid),
        .uart_out_ready (uart_out_ready),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .cmd_has_arg    (cmd_has_arg),
        .cmd_err        (cmd_err),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .echo_data      (echo_data),
        .echo_valid     (echo_valid),
        .echo_ready     (echo_ready)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] arg;
        logic        has;
        logic [1:0]  err;
    } cmd_t;

    cmd_t       exp_q[$];
    logic [7:0] line_q[$];
    logic [7:0] echo_q[$];
    cmd_t       mon_e;
    logic [7:0] mon_b;
    int checks = 0;
    int failures = 0;
    int rdy_mode = 1;
    int echo_mode = 1;
    int ecnt = 0;
    bit gaps_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit is_hex_c(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
    endfunction

    function automatic int hex_val(input logic [7:0] c);
        if (c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h61) return int'(c) - 87;
        return int'(c) - 55;
    endfunction

    // Reference: judge a whole line (bytes before CR) by the command syntax rules
    function automatic void model_line();
        logic [7:0] ch[$];
        cmd_t e;
        int nd;
        foreach (line_q[i]) if (line_q[i] != 8'h0A) ch.push_back(line_q[i]);
        line_q.delete();
        if (ch.size() == 0) return;
        e.op = ch[0]; e.arg = 0; e.has = 0; e.err = 0; nd = 0;
        if (!(ch[0] >= 8'h61 && ch[0] <= 8'h7A)) begin
            e.err = 1;
        end else begin
            for (int i = 1; i < ch.size(); i++) begin
                if (i + 1 > MAX_LINE) begin e.err = 3; break; end
                if (ch[i] == 8'h20) begin
                    if (nd > 0) begin e.err = 2; break; end
                end else if (is_hex_c(ch[i])) begin
                    if (nd == DATA_BITS / 4) begin e.err = 3; break; end
                    e.arg = e.arg * 16 + 32'(hex_val(ch[i]));
                    nd++;
                end else begin
                    e.err = 2; break;
                end
            end
        end
        if (e.err != 0) begin e.arg = 0; e.has = 0; end
        else e.has = (nd > 0);
        exp_q.push_back(e);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            uart_out_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk_48mhz);
            #1;
        end
        uart_out_data = b;
        uart_out_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk_48mhz);
            if (uart_out_ready) break;
            n++;
            if (n > 300) begin
                checks++; failures++;
                $display("FAIL accept_timeout byte=%0h waited=%0d required=accepted", b, n);
                uart_out_valid = 1'b0;
                return;
            end
        end
        @(posedge clk_48mhz);
        #1;
        uart_out_valid = 1'b0;
        echo_q.push_back(b);
        if (b == 8'h0D) model_line();
        else line_q.push_back(b);
    endtask

    // '~' stands for CR and '^' for LF
    task automatic send_str(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h7E) c = 8'h0D;
            else if (c == 8'h5E) c = 8'h0A;
            send_byte(c);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk_48mhz);
            n++;
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_random_line();
        logic [7:0] q[$];
        int nsp, nd, v;
        if ($urandom_range(0, 11) == 0) begin
            if ($urandom_range(0, 1) == 1) q.push_back(8'h0A);
        end else begin
            case ($urandom_range(0, 11))
                0: q.push_back(8'h5A);
                1: q.push_back(8'h35);
                default: q.push_back(8'(8'h61 + $urandom_range(0, 25)));
            endcase
            nsp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            repeat (nsp) q.push_back(8'h20);
            nd = $urandom_range(0, 10);
            for (int i = 0; i < nd; i++) begin
                v = $urandom_range(0, 15);
                if (v < 10) q.push_back(8'(8'h30 + v));
                else q.push_back(8'((($urandom_range(0, 1) == 1) ? 8'h61 : 8'h41) + v - 10));
                if ($urandom_range(0, 19) == 0) q.push_back(($urandom_range(0, 1) == 1) ? 8'h47 : 8'h20);
                if ($urandom_range(0, 9) == 0) q.push_back(8'h0A);
            end
        end
        q.push_back(8'h0D);
        foreach (q[i]) send_byte(q[i]);
    endtask

    always @(posedge clk_48mhz) begin
        #1;
        case (rdy_mode)
            0: cmd_ready = ($urandom_range(0, 1) == 1);
            1: cmd_ready = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
        ecnt = (ecnt + 1) % 3;
        echo_ready = (echo_mode != 0) ? 1'b1 : (ecnt == 0);
    end

    always @(negedge clk_48mhz) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_cmd op=%0h err=%0d required=no_command", cmd_op, cmd_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.err != 2'd1) check("cmd_op", 64'(cmd_op), 64'(mon_e.op));
                check("cmd_arg", 64'(cmd_arg), 64'(mon_e.arg));
                check("cmd_has_arg", 64'(cmd_has_arg), 64'(mon_e.has));
                check("cmd_err", 64'(cmd_err), 64'(mon_e.err));
            end
        end
    end

`ifdef UART_CMD_ECHO_EN
    always @(negedge clk_48mhz) begin
        if (reset_n && echo_valid && echo_ready) begin
            if (echo_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_echo data=%0h required=none", echo_data);
            end else begin
                mon_b = echo_q.pop_front();
                check("echo_data", 64'(echo_data), 64'(mon_b));
            end
        end
    end
`endif

    initial begin
        repeat (3) @(posedge clk_48mhz);
        #1;
        check("rst_ready", 64'(uart_out_ready), 64'd0);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_op", 64'(cmd_op), 64'd0);
        check("rst_arg", 64'(cmd_arg), 64'd0);
        check("rst_has_arg", 64'(cmd_has_arg), 64'd0);
        check("rst_err", 64'(cmd_err), 64'd0);
        check("rst_echo_valid", 64'(echo_valid), 64'd0);
        check("rst_echo_data", 64'(echo_data), 64'd0);
        reset_n = 1'b1;
        @(posedge clk_48mhz);
        #1;
        check("ready_after_reset", 64'(uart_out_ready), 64'd1);

        send_str("a 1F~");
        check("ready_low_after_cr", 64'(uart_out_ready), 64'd0);
        check("valid_after_cr", 64'(cmd_valid), 64'd1);
        @(posedge clk_48mhz);
        #1;
        check("valid_low_after_hs", 64'(cmd_valid), 64'd0);
        check("ready_high_after_hs", 64'(uart_out_ready), 64'd1);

        send_str("cDEADBEEF~c123456789~Z5~b 1G~~^~");
        wait_drain("drain_directed");

        rdy_mode = 2;
        send_str("f~");
        uart_out_data = 8'h67;
        uart_out_valid = 1'b1;
        repeat (20) @(negedge clk_48mhz);
        check("stall_ready", 64'(uart_out_ready), 64'd0);
        check("stall_valid", 64'(cmd_valid), 64'd1);
        check("stall_op", 64'(cmd_op), 64'h66);
        check("stall_has_arg", 64'(cmd_has_arg), 64'd0);
        rdy_mode = 1;
        send_str("g~");
        wait_drain("drain_stall");

        send_str("a 12");
        reset_n = 1'b0;
        #1;
        check("abort_ready", 64'(uart_out_ready), 64'd0);
        check("abort_valid", 64'(cmd_valid), 64'd0);
        check("abort_op", 64'(cmd_op), 64'd0);
        check("abort_arg", 64'(cmd_arg), 64'd0);
        check("abort_has_arg", 64'(cmd_has_arg), 64'd0);
        check("abort_err", 64'(cmd_err), 64'd0);
        line_q.delete();
        echo_q.delete();
        @(posedge clk_48mhz);
        #1;
        reset_n = 1'b1;
        @(posedge clk_48mhz);
        #1;
        send_str("h~");
        wait_drain("drain_after_abort");

        rdy_mode = 0;
        echo_mode = 0;
        gaps_en = 1'b1;
        for (int i = 0; i < 150; i++) send_random_line();
        wait_drain("drain_random");

`ifdef UART_CMD_ECHO_EN
        for (int n = 0; n < 200 && echo_q.size() != 0; n++) @(posedge clk_48mhz);
        #1;
        check("echo_drain", 64'(echo_q.size()), 64'd0);
`else
        check("echo_valid_off", 64'(echo_valid), 64'd0);
        check("echo_data_off", 64'(echo_data), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Line-oriented command parser between the USB UART receive stream (`uart_out_*`) and the CAM command shell. It consumes ASCII bytes and assembles a line of the form `<opcode>[spaces]<hex argument>\r`. It then presents one decoded command (opcode, binary argument, error code) on a valid/ready handshake. The shell no longer does character accumulation or ASCII-to-binary conversion.

## Interface
- `DATA_BITS`, 32: argument width; must be a multiple of 4. Maximum digits = DATA_BITS/4.
- `MAX_LINE`, 16: maximum characters per line, excluding `\r`.
- `clk_48mhz` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `uart_out_data` in 8: received byte.
- `uart_out_valid` in 1: byte present.
- `uart_out_ready` out 1: parser accepts the byte this cycle.
- `cmd_op` out 8: opcode character, `a`..`z`.
- `cmd_arg` out DATA_BITS: hex argument, right-aligned and zero-extended.
- `cmd_has_arg` out 1: at least one hex digit was received.
- `cmd_err` out 2: 0 OK, 1 BAD_OP, 2 BAD_CHAR, 3 OVERFLOW.
- `cmd_valid` out 1 / `cmd_ready` in 1: command handshake.
- `echo_data` out 8, `echo_valid` out 1, `echo_ready` in 1: echo stream toward `uart_in_*`. Active only with `UART_CMD_ECHO_EN`.

## Operation
- Byte accept: `uart_out_valid && uart_out_ready`.
- A byte of `\n` is always dropped with no effect.
- States:
  - IDLE (expect opcode):
    - `\r`: empty line, ignored, stay.
    - `a`..`z`: latch `cmd_op`, clear arg and digit count, set len=1, go ARG.
    - Anything else: err=BAD_OP, go DISCARD.
  - ARG:
    - Space: allowed only before the first digit. After a digit it sets BAD_CHAR and goes to DISCARD.
    - Hex digit `0-9a-fA-F`: arg <= {arg[DATA_BITS-5:0], nibble}, digits++, `cmd_has_arg`=1.
    - A digit arriving when digits == DATA_BITS/4: OVERFLOW, go DISCARD.
    - Any other non-`\r`: BAD_CHAR, go DISCARD.
    - `\r`: go HOLD with err=0.
    - Every non-`\r` byte increments len. When len would exceed MAX_LINE: OVERFLOW, go DISCARD.
  - DISCARD: drop bytes until `\r`, then go HOLD with the latched error. The first error wins. `cmd_arg`=0 and `cmd_has_arg`=0 when err≠0.
  - HOLD: `cmd_valid`=1 and `uart_out_ready`=0. All `cmd_*` outputs stay stable. On `cmd_valid && cmd_ready`, go IDLE.
- Reset (mid-line or mid-HOLD) aborts everything: state=IDLE, partial line lost.

## Timing
- Reset values:
  - `uart_out_ready`=0, `cmd_valid`=0, `cmd_op`=0, `cmd_arg`=0, `cmd_has_arg`=0, `cmd_err`=0.
  - `echo_valid`=0, `echo_data`=0.
- `uart_out_ready` is registered:
  - Rises on the first `clk_48mhz` edge after `reset_n` deasserts.
  - Falls on the edge that accepts the terminating `\r`.
  - Rises again on the edge after the command handshake.
- Latency: `\r` accepted at edge N gives `cmd_valid`=1 after edge N; `cmd_ready` sampled from cycle N+1 onward.
- Throughput: one byte per cycle in IDLE/ARG/DISCARD.
- Handshake completes at edge M. `cmd_valid` goes low after edge M and `uart_out_ready` goes high after edge M. The next byte can be accepted at edge M+1.
- `cmd_ready` asserted while `cmd_valid`=0 has no effect.

## Configuration
- `UART_CMD_ECHO_EN` defined:
  - A one-entry echo buffer captures every accepted byte, including `\r` and `\n`.
  - `echo_valid` rises the cycle after acceptance and holds `echo_data` until `echo_ready`.
  - `uart_out_ready` additionally requires the buffer to be empty, or to be draining this cycle.
- Not defined: `echo_valid` tied 0, `echo_data` tied 0, `echo_ready` ignored. Parser behaviour is otherwise identical.

## Structure
- Package `uart_cmd_pkg`:
  - State enum: IDLE, ARG, DISCARD, HOLD.
  - Error code constants: ERR_NONE, ERR_BAD_OP, ERR_BAD_CHAR, ERR_OVERFLOW.
  - ASCII constants: CR=8'h0D, LF=8'h0A, SP=8'h20.
- Sub-module `hex_nibble_decode`: combinational, 8-bit ASCII in, 4-bit nibble plus `is_hex` out.

## Test plan
- `a 1F\r`, with `cmd_ready` held 1 → one command: op=`a`, arg=0x0000001F, has_arg=1, err=0. Then `uart_out_ready`=1 again two cycles after the `\r`.
- `cDEADBEEF\r` → arg=0xDEADBEEF, err=0. `c123456789\r` → err=3, arg=0, has_arg=0.
- `Z5\r` → err=1. `b 1G\r` → err=2. `\r\n\r` alone → no command issued.
- `cmd_ready` held 0 for 20 cycles after `f\r`, with the next bytes `g\r` already queued → `uart_out_ready`=0 and outputs stable (op=`f`, has_arg=0). After `cmd_ready` pulses, `g` is issued next.
- `reset_n` pulsed low after `a 12` with no `\r` → all outputs zero immediately. A following `h\r` yields op=`h`, has_arg=0.
- With `UART_CMD_ECHO_EN` defined and `echo_ready` toggling 1-of-3 cycles → echo stream equals the input byte sequence exactly, and no input byte is lost.
